// File: rtl/divider_ctrl.sv
// Run-time controller for the counter-based clock divider: takes half-period and
// burst-length configuration, then starts, stops and re-ratios a registered O_CLK.
module divider_ctrl #(
  parameter int W        = 16,
  parameter int CW       = 8,
  parameter int DEF_HALF = 10
) (
  input  logic          I_CLK,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_half,
  input  logic [CW-1:0] cfg_cycles,
  output logic          O_CLK,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] period_cnt,
  output logic [1:0]    o_dbg_state
);

  // Config port: a transfer happens on a rising edge where cfg_valid && cfg_ready.
  // cfg_ready is low only while a shadowed config waits for a period boundary.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [W-1:0]  HALF_RST = W'(DEF_HALF);
  localparam logic [W-1:0]  ONE_W    = W'(1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_clk;
  logic [W-1:0]  r_cnt;
  logic [CW-1:0] r_period_cnt;
  logic [W-1:0]  r_half;
  logic [CW-1:0] r_cycles;
  logic          r_pending;
  logic [W-1:0]  r_sh_half;
  logic [CW-1:0] r_sh_cycles;

  logic          w_cfg_fire;
  logic [W-1:0]  w_cfg_half_eff;
  logic          w_active;
  logic          w_toggle;
  logic          w_fall;
  logic [CW-1:0] w_period_next;
  logic          w_burst_end;
  logic          w_leaving;

  assign w_cfg_fire     = cfg_valid && !r_pending;
  assign w_cfg_half_eff = (cfg_half == '0) ? ONE_W : cfg_half;
  assign w_active       = (r_state == S_RUN) || (r_state == S_STOPPING);
  assign w_toggle       = w_active && (r_cnt == r_half - ONE_W);
  assign w_fall         = w_toggle && r_clk;
  assign w_period_next  = (&r_period_cnt) ? r_period_cnt : r_period_cnt + ONE_C;
  assign w_burst_end    = w_fall && (r_cycles != '0) && (w_period_next == r_cycles);
  // A config landing on the run's final edge must not strand in the shadow.
  assign w_leaving      = w_fall && ((w_state_next == S_IDLE) || (w_state_next == S_DONE));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_burst_end)  w_state_next = S_DONE;
        else if (stop)    w_state_next = S_STOPPING;
      end
      S_STOPPING: begin
        if (w_burst_end)  w_state_next = S_DONE;
        else if (w_fall)  w_state_next = S_IDLE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_clk        <= 1'b0;
      r_cnt        <= '0;
      r_period_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_toggle)       r_clk <= ~r_clk;
      else if (!w_active) r_clk <= 1'b0;
      if (!w_active || w_toggle) r_cnt <= '0;
      else                       r_cnt <= r_cnt + ONE_W;
      if ((r_state == S_IDLE) && start) r_period_cnt <= '0;
      else if (w_fall)                  r_period_cnt <= w_period_next;
    end
  end

  // half_r only changes on a falling toggle while running, so no phase is cut short.
  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_half      <= HALF_RST;
      r_cycles    <= '0;
      r_pending   <= 1'b0;
      r_sh_half   <= HALF_RST;
      r_sh_cycles <= '0;
    end else begin
      if (w_cfg_fire && (!w_active || w_leaving)) begin
        r_half   <= w_cfg_half_eff;
        r_cycles <= cfg_cycles;
      end else if (w_fall && r_pending) begin
        r_half   <= r_sh_half;
        r_cycles <= r_sh_cycles;
      end
      if (w_cfg_fire && w_active && !w_leaving) begin
        r_sh_half   <= w_cfg_half_eff;
        r_sh_cycles <= cfg_cycles;
        r_pending   <= 1'b1;
      end else if (w_fall) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign cfg_ready   = !r_pending;
  assign O_CLK       = r_clk;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign period_cnt  = r_period_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed bench for divider_ctrl: burst table plus hand sequences for
// free-run, mid-run reconfiguration, graceful stop, saturation and async reset.
module tb_divider_ctrl;

  logic        I_CLK = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_half;
  logic [7:0]  cfg_cycles;
  logic        O_CLK;
  logic        busy;
  logic        done;
  logic [7:0]  period_cnt;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  divider_ctrl #(.W(16), .CW(8), .DEF_HALF(10)) dut (
    .I_CLK       (I_CLK),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_half    (cfg_half),
    .cfg_cycles  (cfg_cycles),
    .O_CLK       (O_CLK),
    .busy        (busy),
    .done        (done),
    .period_cnt  (period_cnt),
    .o_dbg_state (dbg_state)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [15:0] half;
    logic [7:0]  cycles;
    int          h_eff;
    int          done_cyc;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge I_CLK);
    #1;
    cyc++;
  endtask

  task automatic adv_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_cfg(input logic [15:0] h, input logic [7:0] c);
    cfg_valid  = 1'b1;
    cfg_half   = h;
    cfg_cycles = c;
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 0;
  endtask

  task automatic stop_and_wait(input string name);
    int budget;
    stop = 1'b1;
    step();
    stop = 1'b0;
    budget = 0;
    while (busy && budget < 300) begin
      step();
      budget++;
    end
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{half: 16'd3, cycles: 8'd4, h_eff: 3, done_cyc: 24, exp_pc: 8'd4};
    vecs[1] = '{half: 16'd0, cycles: 8'd2, h_eff: 1, done_cyc: 4,  exp_pc: 8'd2};
    vecs[2] = '{half: 16'd1, cycles: 8'd3, h_eff: 1, done_cyc: 6,  exp_pc: 8'd3};
    vecs[3] = '{half: 16'd7, cycles: 8'd1, h_eff: 7, done_cyc: 14, exp_pc: 8'd1};
    vecs[4] = '{half: 16'd2, cycles: 8'd5, h_eff: 2, done_cyc: 20, exp_pc: 8'd5};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_valid = 1'b0; cfg_half = '0; cfg_cycles = '0;
    repeat (2) step();
    chk("rst_clk", O_CLK, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_pc", period_cnt, 8'd0);
    chk("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    step();

    // Default ratio, free-run: rise at 10, fall at 20, one period every 20.
    do_start();
    chk("def_busy", busy, 1'b1);
    adv_to(9);  chk("def_clk9", O_CLK, 1'b0);
    adv_to(10); chk("def_clk10", O_CLK, 1'b1);
    adv_to(19); chk("def_clk19", O_CLK, 1'b1);
    adv_to(20); chk("def_clk20", O_CLK, 1'b0);
    chk("def_pc20", period_cnt, 8'd1);
    adv_to(40); chk("def_pc40", period_cnt, 8'd2);
    chk("def_done", done, 1'b0);
    stop_and_wait("def");

    // Finite bursts from the table.
    for (int i = 0; i < 5; i++) begin
      do_cfg(vecs[i].half, vecs[i].cycles);
      do_start();
      for (int k = 1; k <= vecs[i].done_cyc; k++) begin
        step();
        if (k < vecs[i].done_cyc) begin
          chk($sformatf("v%0d_c%0d_clk_done", i, k), {done, O_CLK},
              {1'b0, 1'((k / vecs[i].h_eff) % 2)});
        end
      end
      chk($sformatf("v%0d_done", i), done, 1'b1);
      chk($sformatf("v%0d_done_clk", i), O_CLK, 1'b0);
      chk($sformatf("v%0d_done_busy", i), busy, 1'b1);
      chk($sformatf("v%0d_pc", i), period_cnt, vecs[i].exp_pc);
      step();
      chk($sformatf("v%0d_after_done", i), done, 1'b0);
      chk($sformatf("v%0d_after_busy", i), busy, 1'b0);
      chk($sformatf("v%0d_after_pc", i), period_cnt, vecs[i].exp_pc);
    end

    // Mid-run reconfiguration applies only at the next falling toggle.
    do_cfg(16'd5, 8'd0);
    do_start();
    adv_to(11);
    cfg_valid = 1'b1; cfg_half = 16'd2; cfg_cycles = 8'd0;
    step();
    cfg_valid = 1'b0;
    chk("mid_ready12", cfg_ready, 1'b0);
    adv_to(15); chk("mid_clk15", O_CLK, 1'b1);
    adv_to(19); chk("mid_clk19", O_CLK, 1'b1);
    chk("mid_ready19", cfg_ready, 1'b0);
    adv_to(20); chk("mid_clk20", O_CLK, 1'b0);
    chk("mid_ready20", cfg_ready, 1'b1);
    adv_to(21); chk("mid_clk21", O_CLK, 1'b0);
    adv_to(22); chk("mid_clk22", O_CLK, 1'b1);
    adv_to(23); chk("mid_clk23", O_CLK, 1'b1);
    adv_to(24); chk("mid_clk24", O_CLK, 1'b0);
    chk("mid_pc24", period_cnt, 8'd3);
    stop_and_wait("mid");

    // Graceful stop while O_CLK is low: the period still completes.
    do_cfg(16'd4, 8'd0);
    do_start();
    adv_to(2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stp_clk3", O_CLK, 1'b0);
    chk("stp_busy3", busy, 1'b1);
    adv_to(4); chk("stp_clk4", {done, O_CLK}, 2'b01);
    adv_to(7); chk("stp_clk7", {done, O_CLK}, 2'b01);
    adv_to(8); chk("stp_clk8", {done, O_CLK}, 2'b00);
    chk("stp_busy8", busy, 1'b0);
    chk("stp_pc8", period_cnt, 8'd1);
    adv_to(9); chk("stp_done9", done, 1'b0);

    // Period counter saturates at 255.
    do_cfg(16'd1, 8'd0);
    do_start();
    adv_to(508); chk("sat_pc508", period_cnt, 8'd254);
    adv_to(510); chk("sat_pc510", period_cnt, 8'd255);
    adv_to(600); chk("sat_pc600", period_cnt, 8'd255);
    chk("sat_busy", busy, 1'b1);
    stop_and_wait("sat");

    // Async reset mid-high-phase discards the shadow config and restores defaults.
    do_cfg(16'd3, 8'd0);
    do_start();
    adv_to(1);
    cfg_valid = 1'b1; cfg_half = 16'd7; cfg_cycles = 8'd0;
    step();
    cfg_valid = 1'b0;
    chk("ar_ready2", cfg_ready, 1'b0);
    adv_to(4); chk("ar_clk4", O_CLK, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_clk", O_CLK, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_ready", cfg_ready, 1'b1);
    chk("ar_pc", period_cnt, 8'd0);
    #3 rst_n = 1'b1;
    do_start();
    adv_to(9);  chk("ar_clk9", O_CLK, 1'b0);
    adv_to(10); chk("ar_clk10", O_CLK, 1'b1);
    adv_to(20); chk("ar_clk20", O_CLK, 1'b0);
    adv_to(29); chk("ar_clk29", O_CLK, 1'b0);
    adv_to(30); chk("ar_clk30", O_CLK, 1'b1);
    stop_and_wait("ar");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/divider_ctrl.md
Name: divider_ctrl

Overview:
- Run-time controller for the team's counter-based clock divider.
- Accepts a half-period and a burst length over a valid/ready config port, then starts and stops the divided clock.
- Applies new ratios only at period boundaries, so O_CLK never has runt pulses.
- Emits a done pulse after a finite burst; sits between the system control FSM and divided-clock consumers such as display scan and LED blink.

Parameters:
- W, 16, width of half-period config and internal counter.
- CW, 8, width of burst-length config and period counter.
- DEF_HALF, 10, half-period after reset (divide-by-20).

Ports:
- I_CLK  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- start  in  1  level-sampled; begins generation when in IDLE.
- stop  in  1  level-sampled; graceful stop request.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config can be accepted.
- cfg_half  in  W  half-period in I_CLK cycles; 0 treated as 1.
- cfg_cycles  in  CW  number of O_CLK periods to emit; 0 = free-run.
- O_CLK  out  1  divided clock (registered).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at burst completion.
- period_cnt  out  CW  completed periods in current run.

Behaviour:
- Reset (rst_n low, async): state=IDLE, O_CLK=0, cnt=0, period_cnt=0, done=0, busy=0, cfg_ready=1, half_r=DEF_HALF, cycles_r=0, pending=0.
- States: IDLE, RUN, STOPPING, DONE.
- Config handshake: accept when cfg_valid && cfg_ready.
  - In IDLE/DONE, accepted values load half_r/cycles_r at that edge.
  - In RUN/STOPPING, values go to a shadow register and pending=1; cfg_ready=!pending.
  - Shadow values are copied to half_r/cycles_r at the next falling toggle of O_CLK; pending clears on the same edge.
- IDLE: O_CLK=0, cnt=0. start=1 -> RUN, cnt=0, period_cnt=0. A config accepted on the same edge as start is used for that run. stop is ignored in IDLE.
- RUN/STOPPING counting: cnt increments each cycle. When cnt==half_r-1, O_CLK toggles and cnt resets to 0.
  - O_CLK first rises half_r cycles after the start-sampling edge; full period = 2*half_r cycles.
  - Falling toggle marks a period end: period_cnt increments, saturating at 2^CW-1.
- RUN: stop=1 -> STOPPING. start is ignored.
- Burst end: if cycles_r!=0 and the falling toggle brings period_cnt to cycles_r -> DONE, with done=1 on that same edge. Burst end takes priority over stop.
- STOPPING: continues until the next falling toggle -> IDLE. No done pulse; O_CLK ends low. A burst end on that toggle still goes to DONE with done=1.
- DONE: done=1 for exactly this one cycle, O_CLK=0, then -> IDLE. period_cnt holds until the next start.
- half_r is the value in effect at the start of each half-period. A changed half_r never truncates a phase in progress.
- Async reset mid-run: O_CLK drops immediately and the shadow config is discarded.

Test Plan:
- Reset then start with defaults and cfg_cycles=0 -> O_CLK rises 10 cycles after start, falls at 20, period 20; busy=1; period_cnt increments every 20 cycles.
- Config half=3, cycles=4, then start -> 4 periods of 6 cycles; done high exactly at cycle 24 after start, for 1 cycle; O_CLK=0; busy falls next cycle; period_cnt=4.
- Free-run at half=5; at cycle 12 offer half=2 -> cfg_ready drops; first period stays 10 cycles; new 4-cycle periods begin at the cycle-20 boundary; cfg_ready returns to 1 there.
- Free-run half=4; assert stop at cycle 3 (O_CLK low) -> O_CLK still rises at 4 and falls at 8, then IDLE; no done pulse.
- cfg_half=0, cycles=2 -> treated as half=1; O_CLK toggles every cycle; done at cycle 4.
- Deassert rst_n mid-high-phase between clock edges -> O_CLK=0, busy=0, cfg_ready=1 immediately; after release, half_r=10.
